// File: rtl/pcie_read_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pcie_read_scheduler                                        |
// | Description : Issues 512-byte PCIe read requests from a host-loaded page |
// |               table, limited by downstream credits and 8 tags.           |
// |               Optional macro PCIE_READ_SCHEDULER_STATS_EN adds a stall   |
// |               counter.                                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pcie_read_scheduler #(
   parameter int CREDITS = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pio_write_valid,
   input  logic [12:0] pio_write_address,
   input  logic [63:0] pio_write_data,
   output logic        read_request_valid,
   input  logic        read_request_ready,
   output logic [63:0] read_request_address,
   output logic [7:0]  read_request_tag,
   input  logic        tag_done_valid,
   input  logic [2:0]  tag_done_tag,
   input  logic        credit_return,
   output logic        active,
   output logic        idle,
   output logic [17:0] block_count,
   output logic        interrupt_match,
   output logic        tag_error,
   output logic [31:0] stall_count
);

   localparam logic [7:0] c_full_credits = 8'(CREDITS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      REQ    = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_active;
   logic [17:0] r_match;
   logic [41:0] r_page_table [32];
   logic [7:0]  r_tag_busy;
   logic [7:0]  w_tag_busy_next;
   logic [7:0]  r_credits;
   logic [17:0] r_block_count;
   logic [63:0] r_req_address;
   logic [2:0]  r_req_tag;
   logic        r_interrupt_match;
   logic        r_tag_error;

   logic        w_pio_enable;
   logic        w_pio_disable;
   logic        w_pio_match;
   logic        w_pio_page;
   logic        w_accept;
   logic        w_can_issue;
   logic        w_any_free;
   logic [2:0]  w_free_tag;
   logic        w_tag_err_set;
   logic        w_unused_data;

   assign w_pio_enable  = pio_write_valid && (pio_write_address == 13'd16);
   assign w_pio_disable = pio_write_valid && (pio_write_address == 13'd17);
   assign w_pio_match   = pio_write_valid && (pio_write_address == 13'd18);
   assign w_pio_page    = pio_write_valid && (pio_write_address[12:9] == 4'd2);
   assign w_unused_data = &{1'b0, pio_write_data[8:0]};

   assign w_accept    = (r_state == REQ) && read_request_ready;
   assign w_any_free  = ~&r_tag_busy;
   assign w_can_issue = r_active && (r_credits != 8'd0) && w_any_free;

   // Lowest-numbered free tag wins
   always_comb begin
      w_free_tag = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (!r_tag_busy[i]) begin
            w_free_tag = 3'(i);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next       = r_state;
      read_request_valid = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_can_issue) begin
               w_state_next = LOOKUP;
            end
         end
         LOOKUP: begin
            w_state_next = REQ;
         end
         REQ: begin
            read_request_valid = 1'b1;
            if (read_request_ready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Disable takes priority over enable
   always_ff @(posedge clock) begin
      if (reset) begin
         r_active <= 1'b0;
      end else if (w_pio_disable) begin
         r_active <= 1'b0;
      end else if (w_pio_enable) begin
         r_active <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_match <= 18'd0;
      end else if (w_pio_match) begin
         r_match <= pio_write_data[26:9];
      end
   end

   always_ff @(posedge clock) begin
      if (w_pio_page) begin
         r_page_table[pio_write_address[4:0]] <= pio_write_data[63:22];
      end
   end

   // Whole address is captured so a later enable cannot disturb a raised request
   always_ff @(posedge clock) begin
      if (reset) begin
         r_req_address <= 64'd0;
         r_req_tag     <= 3'd0;
      end else if (r_state == LOOKUP) begin
         r_req_address <= {r_page_table[r_block_count[17:13]], r_block_count[12:0], 9'd0};
         r_req_tag     <= w_free_tag;
      end
   end

   // A simultaneous return and acceptance cancel out
   always_ff @(posedge clock) begin
      if (reset) begin
         r_credits <= 8'd0;
      end else if (w_pio_enable && !w_pio_disable) begin
         r_credits <= c_full_credits;
      end else if (w_accept && !credit_return) begin
         r_credits <= r_credits - 8'd1;
      end else if (!w_accept && credit_return && (r_credits != c_full_credits)) begin
         r_credits <= r_credits + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_block_count <= 18'd0;
      end else if (w_pio_enable && !w_pio_disable) begin
         r_block_count <= 18'd0;
      end else if (w_accept) begin
         r_block_count <= r_block_count + 18'd1;
      end
   end

   // Done is judged against the current busy state; acceptance then claims its tag
   always_comb begin
      w_tag_busy_next = r_tag_busy;
      w_tag_err_set   = 1'b0;
      if (tag_done_valid) begin
         if (r_tag_busy[tag_done_tag]) begin
            w_tag_busy_next[tag_done_tag] = 1'b0;
         end else begin
            w_tag_err_set = 1'b1;
         end
      end
      if (w_accept) begin
         w_tag_busy_next[r_req_tag] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_tag_busy        <= 8'd0;
         r_tag_error       <= 1'b0;
         r_interrupt_match <= 1'b0;
      end else begin
         r_tag_busy        <= w_tag_busy_next;
         r_tag_error       <= r_tag_error | w_tag_err_set;
         r_interrupt_match <= w_accept && ((r_block_count + 18'd1) == r_match);
      end
   end

`ifdef PCIE_READ_SCHEDULER_STATS_EN
   logic [31:0] r_stall_count;
   logic        w_stall;
   logic        w_pio_stall_clear;

   assign w_pio_stall_clear = pio_write_valid && (pio_write_address == 13'd19);
   assign w_stall = r_active && (r_state == IDLE) && ((r_credits == 8'd0) || (&r_tag_busy));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall_count <= 32'd0;
      end else if (w_pio_stall_clear) begin
         r_stall_count <= 32'd0;
      end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
         r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign stall_count = r_stall_count;
`else
   assign stall_count = 32'd0;
`endif

   assign read_request_address = r_req_address;
   assign read_request_tag     = {5'd0, r_req_tag};
   assign active               = r_active;
   assign idle                 = (r_state == IDLE) && (r_tag_busy == 8'd0);
   assign block_count          = r_block_count;
   assign interrupt_match      = r_interrupt_match;
   assign tag_error            = r_tag_error;

endmodule
`default_nettype wire

// File: tb/tb_pcie_read_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pcie_read_scheduler                                     |
// | Description : Directed self-checking bench; instance 0 has 16 credits,   |
// |               instance 1 has 2 credits.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pcie_read_scheduler;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic        pw_v   [2];
   logic [12:0] pw_a   [2];
   logic [63:0] pw_d   [2];
   logic        rdy    [2];
   logic        done_v [2];
   logic [2:0]  done_t [2];
   logic        cret   [2];
   logic        rv     [2];
   logic [63:0] raddr  [2];
   logic [7:0]  rtag   [2];
   logic        act    [2];
   logic        idl    [2];
   logic [17:0] bc     [2];
   logic        im     [2];
   logic        terr   [2];
   logic [31:0] sc     [2];

   pcie_read_scheduler #(.CREDITS(16)) u_dut_c16 (
      .clock(clock), .reset(reset),
      .pio_write_valid(pw_v[0]), .pio_write_address(pw_a[0]), .pio_write_data(pw_d[0]),
      .read_request_valid(rv[0]), .read_request_ready(rdy[0]),
      .read_request_address(raddr[0]), .read_request_tag(rtag[0]),
      .tag_done_valid(done_v[0]), .tag_done_tag(done_t[0]), .credit_return(cret[0]),
      .active(act[0]), .idle(idl[0]), .block_count(bc[0]),
      .interrupt_match(im[0]), .tag_error(terr[0]), .stall_count(sc[0])
   );

   pcie_read_scheduler #(.CREDITS(2)) u_dut_c2 (
      .clock(clock), .reset(reset),
      .pio_write_valid(pw_v[1]), .pio_write_address(pw_a[1]), .pio_write_data(pw_d[1]),
      .read_request_valid(rv[1]), .read_request_ready(rdy[1]),
      .read_request_address(raddr[1]), .read_request_tag(rtag[1]),
      .tag_done_valid(done_v[1]), .tag_done_tag(done_t[1]), .credit_return(cret[1]),
      .active(act[1]), .idle(idl[1]), .block_count(bc[1]),
      .interrupt_match(im[1]), .tag_error(terr[1]), .stall_count(sc[1])
   );

   int          total = 0;
   int          bad   = 0;
   bit          auto_done [2];
   bit          auto_cret [2];
   bit          pend      [2];
   logic [2:0]  pend_tag  [2];
   bit          md_v      [2];
   logic [2:0]  md_t      [2];
   bit          mc        [2];
   int          acc_n     [2];
   logic [63:0] acc_addr  [2];
   logic [7:0]  acc_tag   [2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: apply responses to last cycle's acceptance, log this cycle's one
   task automatic cyc();
      for (int k = 0; k < 2; k++) begin
         done_v[k] = (auto_done[k] && pend[k]) || md_v[k];
         done_t[k] = md_v[k] ? md_t[k] : pend_tag[k];
         cret[k]   = (auto_cret[k] && pend[k]) || mc[k];
         pend[k]   = (rv[k] === 1'b1) && rdy[k];
         if (pend[k]) begin
            acc_n[k]++;
            acc_addr[k] = raddr[k];
            acc_tag[k]  = rtag[k];
            pend_tag[k] = rtag[k][2:0];
         end
      end
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         md_v[k] = 1'b0;
         mc[k]   = 1'b0;
      end
   endtask

   task automatic pio(input int k, input logic [12:0] a, input logic [63:0] d);
      pw_v[k] = 1'b1;
      pw_a[k] = a;
      pw_d[k] = d;
      cyc();
      pw_v[k] = 1'b0;
   endtask

   initial begin
      int base;
      int guard;
      int exp_tag;
      int im_cnt;
      int im_at;

      for (int k = 0; k < 2; k++) begin
         pw_v[k] = 0; pw_a[k] = 0; pw_d[k] = 0; rdy[k] = 0;
         done_v[k] = 0; done_t[k] = 0; cret[k] = 0;
         auto_done[k] = 0; auto_cret[k] = 0; pend[k] = 0; pend_tag[k] = 0;
         md_v[k] = 0; md_t[k] = 0; mc[k] = 0; acc_n[k] = 0;
         acc_addr[k] = 0; acc_tag[k] = 0;
      end
      reset = 1'b1;
      @(negedge clock);
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      check("rst_valid", rv[0], 0);
      check("rst_idle", idl[0], 1);
      check("rst_active", act[0], 0);
      check("rst_bc", bc[0], 0);
      check("rst_im", im[0], 0);
      check("rst_terr", terr[0], 0);
      check("rst_stall", sc[0], 0);
      check("rst_valid_c2", rv[1], 0);

      // Page-table walk
      pio(0, 13'h400, 64'h0000_0001_0000_0000);
      pio(0, 13'h401, 64'h0000_0000_4000_0000);
      rdy[0] = 1; auto_done[0] = 1; auto_cret[0] = 1;
      check("pre_en_active", act[0], 0);
      pio(0, 13'd16, 64'd0);
      check("en_active", act[0], 1);
      check("lat0_valid", rv[0], 0);
      cyc();
      check("lat1_valid", rv[0], 0);
      cyc();
      check("lat2_valid", rv[0], 1);
      check("first_addr", raddr[0], 64'h0000_0001_0000_0000);
      check("first_tag", rtag[0], 0);
      cyc();
      check("first_bc", bc[0], 1);
      guard = 0;
      while (acc_n[0] < 2 && guard < 20) begin cyc(); guard++; end
      check("second_addr", acc_addr[0], 64'h0000_0001_0000_0200);
      check("second_tag", acc_tag[0], 0);
      guard = 0;
      while (acc_n[0] < 8192 && guard < 30000) begin cyc(); guard++; end
      check("walk_8191_addr", acc_addr[0], 64'h0000_0001_003F_FE00);
      check("walk_bc", bc[0], 8192);
      guard = 0;
      while (acc_n[0] < 8193 && guard < 20) begin cyc(); guard++; end
      check("walk_8192_addr", acc_addr[0], 64'h0000_0000_4000_0000);
      pio(0, 13'd17, 64'd0);
      repeat (8) cyc();
      check("walk_off_valid", rv[0], 0);
      check("walk_off_idle", idl[0], 1);

      // Tag exhaustion
      auto_done[0] = 0; auto_cret[0] = 0;
      pio(0, 13'd16, 64'd0);
      check("reen_bc_clear", bc[0], 0);
      base = acc_n[0];
      exp_tag = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (acc_n[0] - base > exp_tag) begin
            check($sformatf("exh_tag%0d", exp_tag), acc_tag[0], exp_tag);
            exp_tag++;
         end
      end
      check("exh_count", acc_n[0] - base, 8);
      check("exh_valid", rv[0], 0);
      check("exh_not_idle", idl[0], 0);
      md_v[0] = 1; md_t[0] = 3'd3;
      cyc();
      check("done3_c1", rv[0], 0);
      cyc();
      check("done3_c2", rv[0], 0);
      cyc();
      check("done3_c3", rv[0], 1);
      check("done3_tag", rtag[0], 3);
      cyc();
      pio(0, 13'd17, 64'd0);
      for (int t = 0; t < 8; t++) begin md_v[0] = 1; md_t[0] = 3'(t); cyc(); end
      cyc();
      check("exh_idle", idl[0], 1);
      check("exh_no_err", terr[0], 0);

      // Credit limit on the 2-credit instance; early returns arrive at full credit
      rdy[1] = 1; auto_done[1] = 1;
      pio(1, 13'd16, 64'd0);
      mc[1] = 1; cyc();
      mc[1] = 1; cyc();
      repeat (30) cyc();
      check("cred_two", acc_n[1], 2);
      check("cred_stall_valid", rv[1], 0);
`ifdef PCIE_READ_SCHEDULER_STATS_EN
      check("stall_nonzero", sc[1] != 32'd0, 1);
      pio(1, 13'd19, 64'd0);
      check("stall_clear", sc[1], 0);
`else
      check("stall_const0", sc[1], 0);
`endif
      mc[1] = 1; cyc();
      repeat (30) cyc();
      check("cred_three", acc_n[1], 3);
      check("cred_three_valid", rv[1], 0);
      check("cred_bc", bc[1], 3);
      pio(1, 13'd17, 64'd0);

      // Backpressure with disable during REQ
      rdy[0] = 0; auto_done[0] = 1; auto_cret[0] = 1;
      pio(0, 13'd16, 64'd0);
      guard = 0;
      while (rv[0] !== 1'b1 && guard < 10) begin cyc(); guard++; end
      check("bp_valid", rv[0], 1);
      check("bp_addr", raddr[0], 64'h0000_0001_0000_0000);
      check("bp_tag", rtag[0], 0);
      pio(0, 13'd17, 64'd0);
      for (int i = 0; i < 9; i++) begin
         check("bp_hold_valid", rv[0], 1);
         check("bp_hold_addr", raddr[0], 64'h0000_0001_0000_0000);
         check("bp_hold_tag", rtag[0], 0);
         cyc();
      end
      check("bp_inactive", act[0], 0);
      base = acc_n[0];
      rdy[0] = 1;
      cyc();
      check("bp_accept", acc_n[0] - base, 1);
      repeat (20) cyc();
      check("bp_no_more", acc_n[0] - base, 1);
      check("bp_bc", bc[0], 1);
      check("bp_idle", idl[0], 1);

      // Match interrupt after the third acceptance
      pio(0, 13'd18, 64'h600);
      pio(0, 13'd16, 64'd0);
      base = acc_n[0];
      im_cnt = 0;
      im_at = 0;
      guard = 0;
      while (acc_n[0] - base < 5 && guard < 40) begin
         cyc();
         guard++;
         if (im[0] === 1'b1) begin im_cnt++; im_at = acc_n[0] - base; end
      end
      check("match_pulses", im_cnt, 1);
      check("match_at_accept", im_at, 3);
      pio(0, 13'd17, 64'd0);
      repeat (8) cyc();
      check("match_drain_idle", idl[0], 1);
      check("pre_err_terr", terr[0], 0);

      // Done for a free tag
      md_v[0] = 1; md_t[0] = 3'd5;
      cyc();
      check("err_set", terr[0], 1);
      check("err_tags_unchanged", idl[0], 1);
      repeat (5) cyc();
      check("err_sticky", terr[0], 1);

      // Reset while a request is raised
      rdy[0] = 0;
      pio(0, 13'd16, 64'd0);
      guard = 0;
      while (rv[0] !== 1'b1 && guard < 10) begin cyc(); guard++; end
      rdy[0] = 1;
      cyc();
      rdy[0] = 0;
      guard = 0;
      while (rv[0] !== 1'b1 && guard < 10) begin cyc(); guard++; end
      check("prerst_valid", rv[0], 1);
      check("prerst_bc", bc[0], 1);
      check("prerst_terr", terr[0], 1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("midrst_valid", rv[0], 0);
      check("midrst_idle", idl[0], 1);
      check("midrst_bc", bc[0], 0);
      check("midrst_terr", terr[0], 0);
      check("midrst_active", act[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
